// File: rtl/shuffle_s_if.sv
// S-RAM / handshake bundle for the RC4 key-scheduling stage.
// master = environment (start, key, RAM read data); slave = shuffle_s.
interface shuffle_s_if #(
  parameter int unsigned KEY_LENGTH = 3
);
  logic                      start;
  logic [KEY_LENGTH*8-1:0]   secret_key;
  logic [7:0]                q;
  logic [7:0]                address;
  logic [7:0]                data;
  logic                      wren;
  logic                      selector;
  logic                      finish;

  modport master (
    output start, secret_key, q,
    input  address, data, wren, selector, finish
  );

  modport slave (
    input  start, secret_key, q,
    output address, data, wren, selector, finish
  );
endinterface

// File: rtl/shuffle_s.sv
// RC4 key schedule: 256 in-place swaps j=j+s[i]+key[i mod KEY_LENGTH] on a single-port S RAM
// with 2-cycle read latency; 8 cycles per iteration, one-cycle finish pulse at the end.
module shuffle_s #(
  parameter int unsigned KEY_LENGTH = 3
) (
  input  logic        clk,
  input  logic        reset,
  shuffle_s_if.slave  bus
);

  localparam int unsigned KW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;

  typedef enum logic [3:0] {
    IDLE, RD_I, WAIT_I, CAP_I, RD_J, WAIT_J, CAP_J, WR_I, WR_J, DONE
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    i_q, i_d;
  logic [7:0]    j_q, j_d;
  logic [KW-1:0] k_q, k_d;
  logic [7:0]    si_q, si_d;
  logic [7:0]    sj_q, sj_d;
  logic [7:0]    key_byte_c;

  // Byte 0 of the key sits in the most significant byte lane.
  always_comb begin
    key_byte_c = 8'(bus.secret_key >> (8 * (KEY_LENGTH - 1 - 32'(k_q))));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= 8'h00;
      j_q     <= 8'h00;
      k_q     <= '0;
      si_q    <= 8'h00;
      sj_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    j_d          = j_q;
    k_d          = k_q;
    si_d         = si_q;
    sj_d         = sj_q;
    bus.address  = 8'h00;
    bus.data     = 8'h00;
    bus.wren     = 1'b0;
    bus.finish   = 1'b0;
    bus.selector = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RD_I;
          i_d     = 8'h00;
          j_d     = 8'h00;
          k_d     = '0;
        end
      end
      RD_I: begin
        bus.address = i_q;
        state_d     = WAIT_I;
      end
      WAIT_I: begin
        bus.address = i_q;
        state_d     = CAP_I;
      end
      CAP_I: begin
        si_d    = bus.q;
        j_d     = j_q + bus.q + key_byte_c;
        state_d = RD_J;
      end
      RD_J: begin
        bus.address = j_q;
        state_d     = WAIT_J;
      end
      WAIT_J: begin
        bus.address = j_q;
        state_d     = CAP_J;
      end
      CAP_J: begin
        sj_d    = bus.q;
        state_d = WR_I;
      end
      WR_I: begin
        bus.address = i_q;
        bus.data    = sj_q;
        bus.wren    = 1'b1;
        state_d     = WR_J;
      end
      WR_J: begin
        bus.address = j_q;
        bus.data    = si_q;
        bus.wren    = 1'b1;
        i_d         = i_q + 8'd1;
        // Wrapping key index avoids an i mod KEY_LENGTH divider.
        k_d         = (k_q == KW'(KEY_LENGTH - 1)) ? '0 : k_q + KW'(1);
        state_d     = (i_q == 8'hFF) ? DONE : RD_I;
      end
      DONE: begin
        bus.finish = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
